// File: rtl/clock_set_controller_if.sv
// Key and counter-command bundle for the time-of-day set path.
// master: drives raw keys, sees commands. slave: the controller.
interface clock_set_controller_if;
  logic       keyMode;
  logic       keyUp;
  logic       keyDown;
  logic       on;
  logic       set;
  logic [1:0] sethms;
  logic [1:0] upDown;
  logic       blink;

  modport master (
    output keyMode, keyUp, keyDown,
    input  on, set, sethms, upDown, blink
  );

  modport slave (
    input  keyMode, keyUp, keyDown,
    output on, set, sethms, upDown, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// Set-path sequencer: key conditioning, RUN/SET_* mode machine,
// auto-repeat, blink, idle timeout.
// Ports: clk, rst (sync, active-high), bus (slave):
//   in  keyMode/keyUp/keyDown (raw, active-low)
//   out on, set, sethms[1:0], upDown[1:0], blink
module clock_set_controller #(
  parameter int DEBOUNCE     = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int BLINK_HALF   = 12500000,
  parameter int IDLE_TIMEOUT = 500000000
) (
  input logic clk,
  input logic rst,
  clock_set_controller_if.slave bus
);

  localparam int RMX = (REPEAT_DELAY > REPEAT_RATE) ?
                       REPEAT_DELAY : REPEAT_RATE;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int RPW = $clog2(RMX + 1);
  localparam int BLW = $clog2(BLINK_HALF + 1);
  localparam int IDW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE);
  localparam logic [RPW-1:0] RP_DLY  = RPW'(REPEAT_DELAY);
  localparam logic [RPW-1:0] RP_RATE = RPW'(REPEAT_RATE);
  localparam logic [RPW-1:0] RP_MAX  = RPW'(RMX);
  localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(IDLE_TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_MAX  = IDW'(IDLE_TIMEOUT);

  // Encoding matches the sethms field code.
  typedef enum logic [1:0] {
    SET_HOUR = 2'b00,
    SET_MIN  = 2'b01,
    SET_SEC  = 2'b10,
    RUN      = 2'b11
  } state_e;

  // Key index: 0 mode, 1 up, 2 down.
  logic [2:0]     raw;
  logic [2:0]     sync1_q;
  logic [2:0]     sync2_q;
  logic [2:0]     stable_q;
  logic [2:0]     evt_q;
  logic [DBW-1:0] db_q [3];

  assign raw = {bus.keyDown, bus.keyUp, bus.keyMode};

  // Synchronisers reset to the raw released level (high);
  // stable levels are in pressed=1 form and reset to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '0;
      evt_q    <= '0;
      for (int i = 0; i < 3; i++) db_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      evt_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        if (~sync2_q[i] != stable_q[i]) begin
          if (db_q[i] == DB_LAST) begin
            stable_q[i] <= ~stable_q[i];
            evt_q[i]    <= ~stable_q[i];
            db_q[i]     <= '0;
          end else if (db_q[i] != DB_MAX) begin
            db_q[i] <= db_q[i] + DBW'(1);
          end
        end else begin
          db_q[i] <= '0;
        end
      end
    end
  end

  state_e         state_q, state_d, nxt_mode;
  logic           on_q, set_q, blink_q;
  logic [1:0]     sethms_q, ud_q;
  logic [RPW-1:0] rpt_q, rpt_d, rpt_tgt;
  logic           rpt_ph_q, rpt_ph_d;
  logic [IDW-1:0] idle_q, idle_d;
  logic [BLW-1:0] bcnt_q, bcnt_d;
  logic           blink_d;

  logic mode_evt, up_evt, dn_evt, ud_evt, any_evt;
  logic up_s, dn_s, solo;
  logic in_set, idle_to, leave, ok;
  logic rpt_hit, up_cmd, dn_cmd;

  assign mode_evt = evt_q[0];
  assign up_evt   = evt_q[1];
  assign dn_evt   = evt_q[2];
  assign ud_evt   = up_evt | dn_evt;
  assign any_evt  = |evt_q;
  assign up_s     = stable_q[1];
  assign dn_s     = stable_q[2];
  assign solo     = up_s ^ dn_s;
  assign in_set   = (state_q != RUN);

  always_comb begin
    nxt_mode = RUN;
    unique case (state_q)
      RUN:      nxt_mode = SET_HOUR;
      SET_HOUR: nxt_mode = SET_MIN;
      SET_MIN:  nxt_mode = SET_SEC;
      SET_SEC:  nxt_mode = RUN;
      default:  nxt_mode = RUN;
    endcase
  end

  // A mode press or timeout owns the cycle: no command with it.
  always_comb begin
    idle_to = in_set & ~any_evt & (idle_q == ID_LAST);
    leave   = mode_evt | idle_to;
    ok      = in_set & ~leave;
    state_d = state_q;
    if (mode_evt)     state_d = nxt_mode;
    else if (idle_to) state_d = RUN;

    rpt_tgt = rpt_ph_q ? RP_RATE : RP_DLY;
    rpt_hit = solo & ~ud_evt & (rpt_q == rpt_tgt);
    up_cmd  = ok & up_s & ~dn_s & (up_evt | rpt_hit);
    dn_cmd  = ok & dn_s & ~up_s & (dn_evt | rpt_hit);
  end

  // Repeat counter restarts at 1 on a press so the
  // first repeat lands exactly REPEAT_DELAY after it.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_ph_d = rpt_ph_q;
    if (!in_set || !solo || leave) begin
      rpt_d    = '0;
      rpt_ph_d = 1'b0;
    end else if (ud_evt) begin
      rpt_d    = RPW'(1);
      rpt_ph_d = 1'b0;
    end else if (rpt_hit) begin
      rpt_d    = RPW'(1);
      rpt_ph_d = 1'b1;
    end else if (rpt_q != RP_MAX) begin
      rpt_d = rpt_q + RPW'(1);
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (!in_set || leave || any_evt) idle_d = '0;
    else if (idle_q != ID_MAX)       idle_d = idle_q + IDW'(1);
  end

  always_comb begin
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (leave) begin
      blink_d = (state_d != RUN);
      bcnt_d  = '0;
    end else if (!in_set) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (bcnt_q == BL_LAST) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + BLW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      on_q     <= 1'b1;
      set_q    <= 1'b0;
      sethms_q <= 2'b11;
      ud_q     <= 2'b00;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
      idle_q   <= '0;
      rpt_q    <= '0;
      rpt_ph_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= (state_d == RUN);
      sethms_q <= state_d;
      set_q    <= up_cmd | dn_cmd;
      ud_q     <= {up_cmd, dn_cmd};
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      idle_q   <= idle_d;
      rpt_q    <= rpt_d;
      rpt_ph_q <= rpt_ph_d;
    end
  end

  assign bus.on     = on_q;
  assign bus.set    = set_q;
  assign bus.sethms = sethms_q;
  assign bus.upDown = ud_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller with shortened timing
// parameters; set pulses are matched against a queue.
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_set_controller_if ifc ();

  clock_set_controller #(
    .DEBOUNCE    (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5),
    .BLINK_HALF  (8),
    .IDLE_TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct {
    int         c;
    logic [1:0] ud;
  } pulse_t;

  typedef struct {
    logic [1:0] sethms;
    logic       on;
    logic       blink;
  } vec_t;

  pulse_t exp_q[$];
  pulse_t mon_e;

  // Scoreboard: every set pulse must match the queue head.
  always @(negedge clk) begin
    if (ifc.set) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_set cyc=%0d upDown=%b want none",
                 cyc, ifc.upDown);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.c != cyc || mon_e.ud != ifc.upDown) begin
          errors++;
          $display("FAIL set_pulse got cyc=%0d ud=%b want cyc=%0d ud=%b",
                   cyc, ifc.upDown, mon_e.c, mon_e.ud);
        end
      end
    end else if (ifc.upDown != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL updown_idle cyc=%0d got=%b want=00",
               cyc, ifc.upDown);
    end
  end

  task automatic check(input string nm, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, req);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic push(input int c, input logic [1:0] ud);
    pulse_t p;
    p.c  = c;
    p.ud = ud;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.keyMode = 1'b1;
    ifc.keyUp   = 1'b1;
    ifc.keyDown = 1'b1;
    go_to(cyc + 3);
    rst = 1'b0;
    go_to(cyc + 2);
  endtask

  task automatic mode_press();
    int n;
    @(posedge clk);
    #1;
    ifc.keyMode = 1'b0;
    n = cyc;
    go_to(n + 10);
    ifc.keyMode = 1'b1;
    go_to(n + 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [4];
    logic [1:0] prev;
    int         n, r, e, p0;

    ifc.keyMode = 1'b1;
    ifc.keyUp   = 1'b1;
    ifc.keyDown = 1'b1;
    go_to(3);
    rst = 1'b0;

    // Idle after reset: {on,set,sethms,blink} = 1,0,11,0.
    repeat (50) begin
      @(negedge clk);
      check("reset_idle",
            {ifc.on, ifc.set, ifc.sethms, ifc.blink}, 5'b1_0_11_0);
    end

    // Mode stepping, change 7 cycles after the raw fall.
    tbl[0] = '{sethms: 2'b00, on: 1'b0, blink: 1'b1};
    tbl[1] = '{sethms: 2'b01, on: 1'b0, blink: 1'b1};
    tbl[2] = '{sethms: 2'b10, on: 1'b0, blink: 1'b1};
    tbl[3] = '{sethms: 2'b11, on: 1'b1, blink: 1'b0};
    prev = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      ifc.keyMode = 1'b0;
      n = cyc;
      sample_at(n + 6);
      check("mode_pre", ifc.sethms, prev);
      sample_at(n + 7);
      check("mode_step", {ifc.on, ifc.sethms, ifc.blink},
            {tbl[i].on, tbl[i].sethms, tbl[i].blink});
      go_to(n + 10);
      ifc.keyMode = 1'b1;
      go_to(n + 20);
      prev = tbl[i].sethms;
    end

    // SET_MIN, up held 40 cycles: stable level stays high
    // for 40 cycles, so repeats land at +27,+32,+37,+42.
    do_reset();
    mode_press();
    mode_press();
    check("in_min", ifc.sethms, 2'b01);
    p0 = pulses;
    @(posedge clk);
    #1;
    ifc.keyUp = 1'b0;
    n = cyc;
    push(n + 7, 2'b10);
    push(n + 27, 2'b10);
    push(n + 32, 2'b10);
    push(n + 37, 2'b10);
    push(n + 42, 2'b10);
    go_to(n + 40);
    ifc.keyUp = 1'b1;
    sample_at(n + 60);
    check("up_count", pulses - p0, 5);

    // SET_HOUR, both held: silent; then down alone
    // repeats after a fresh delay from up's stable release.
    do_reset();
    mode_press();
    check("in_hour", ifc.sethms, 2'b00);
    p0 = pulses;
    @(posedge clk);
    #1;
    ifc.keyUp   = 1'b0;
    ifc.keyDown = 1'b0;
    n = cyc;
    go_to(n + 30);
    ifc.keyUp = 1'b1;
    r = cyc;
    push(r + 27, 2'b01);
    push(r + 32, 2'b01);
    go_to(r + 30);
    ifc.keyDown = 1'b1;
    sample_at(r + 45);
    check("both_count", pulses - p0, 2);

    // Bouncing up key: 2-cycle glitches are rejected.
    do_reset();
    mode_press();
    p0 = pulses;
    @(posedge clk);
    #1;
    n = cyc;
    for (int j = 0; j < 5; j++) begin
      ifc.keyUp = 1'b0;
      go_to(n + 4 * j + 2);
      ifc.keyUp = 1'b1;
      go_to(n + 4 * j + 4);
    end
    sample_at(n + 35);
    check("bounce_count", pulses - p0, 0);
    check("bounce_state", {ifc.on, ifc.sethms}, 3'b0_00);

    // SET_SEC idle: blink period 16, timeout at entry+100.
    do_reset();
    mode_press();
    mode_press();
    @(posedge clk);
    #1;
    ifc.keyMode = 1'b0;
    n = cyc;
    e = n + 7;
    sample_at(e - 1);
    check("sec_pre", ifc.sethms, 2'b01);
    for (int k = 0; k < 100; k++) begin
      sample_at(e + k);
      if (k == 3) ifc.keyMode = 1'b1;
      check("sec_blink", {ifc.on, ifc.sethms, ifc.blink},
            {1'b0, 2'b10, ((k / 8) % 2 == 0)});
    end
    sample_at(e + 100);
    check("timeout", {ifc.on, ifc.sethms, ifc.blink}, 4'b1_11_0);

    // Reset in the middle of an up repeat.
    do_reset();
    mode_press();
    p0 = pulses;
    @(posedge clk);
    #1;
    ifc.keyUp = 1'b0;
    n = cyc;
    push(n + 7, 2'b10);
    push(n + 27, 2'b10);
    go_to(n + 30);
    rst = 1'b1;
    ifc.keyUp = 1'b1;
    sample_at(n + 31);
    check("rst_mid",
          {ifc.on, ifc.set, ifc.sethms, ifc.upDown, ifc.blink},
          7'b1_0_11_00_0);
    go_to(n + 33);
    rst = 1'b0;
    sample_at(n + 55);
    check("rst_count", pulses - p0, 2);
    check("rst_state", {ifc.on, ifc.sethms, ifc.blink}, 4'b1_11_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
